// File: rtl/segment_7_display.sv
// Registered single-digit BCD/hex to 7-segment decoder with blanking,
// lamp test and selectable output polarity. One clock of latency.
module segment_7_display #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i,
  input  logic       blank,
  input  logic       lamp_test,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       invalid
);

  // Segment vectors are ordered {a,b,c,d,e,f,g}, bit 6 = a.
  localparam logic [6:0] SEG_ALL_ON  = 7'b111_1111;
  localparam logic [6:0] SEG_ALL_OFF = 7'b000_0000;
  localparam logic [6:0] SEG_RESET   = ACTIVE_LOW ? SEG_ALL_ON : SEG_ALL_OFF;

  logic [6:0] glyph;
  logic       code_is_hex;
  logic [6:0] seg_logic_next;
  logic       invalid_next;
  logic [6:0] seg_phys_next;
  logic [6:0] seg_reg;
  logic       invalid_reg;

  assign code_is_hex = (i > 4'd9);

  always_comb begin
    glyph = SEG_ALL_OFF;
    case (i)
      4'h0: glyph = 7'b111_1110;
      4'h1: glyph = 7'b011_0000;
      4'h2: glyph = 7'b110_1101;
      4'h3: glyph = 7'b111_1001;
      4'h4: glyph = 7'b011_0011;
      4'h5: glyph = 7'b101_1011;
      4'h6: glyph = 7'b101_1111;
      4'h7: glyph = 7'b111_0000;
      4'h8: glyph = 7'b111_1111;
      4'h9: glyph = 7'b111_1011;
      4'hA: glyph = 7'b111_0111;
      4'hB: glyph = 7'b001_1111;
      4'hC: glyph = 7'b100_1110;
      4'hD: glyph = 7'b011_1101;
      4'hE: glyph = 7'b100_1111;
      4'hF: glyph = 7'b100_0111;
      default: glyph = SEG_ALL_OFF;
    endcase
  end

  // Priority: lamp test over blank over decode; reset is handled in the register.
  always_comb begin
    seg_logic_next = glyph;
    invalid_next   = 1'b0;
    if (lamp_test) begin
      seg_logic_next = SEG_ALL_ON;
    end else if (blank) begin
      seg_logic_next = SEG_ALL_OFF;
    end else if (code_is_hex && !HEX_EN) begin
      seg_logic_next = SEG_ALL_OFF;
      invalid_next   = 1'b1;
    end
  end

  // Polarity is applied last so only the segment drives are affected.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_polarity
      assign seg_phys_next[gi] = ACTIVE_LOW ? ~seg_logic_next[gi] : seg_logic_next[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg     <= SEG_RESET;
      invalid_reg <= 1'b0;
    end else begin
      seg_reg     <= seg_phys_next;
      invalid_reg <= invalid_next;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_reg;
  assign invalid               = invalid_reg;

endmodule

// File: tb/tb_segment_7_display.sv
// Bench for segment_7_display: three parameter variants driven in parallel,
// checked every cycle against a table model plus literal spot checks.
module tb_segment_7_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i = 4'd0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;

  logic a0, b0, c0, d0, e0, f0, g0, inv0;
  logic a1, b1, c1, d1, e1, f1, g1, inv1;
  logic a2, b2, c2, d2, e2, f2, g2, inv2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // dut0: active-high, hex; dut1: active-high, no hex; dut2: active-low, hex
  segment_7_display #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .i(i), .blank(blank), .lamp_test(lamp_test),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0), .invalid(inv0));
  segment_7_display #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .i(i), .blank(blank), .lamp_test(lamp_test),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .invalid(inv1));
  segment_7_display #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) dut2 (
    .clk(clk), .rst(rst), .i(i), .blank(blank), .lamp_test(lamp_test),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .g(g2), .invalid(inv2));

  logic [6:0] seg0, seg1, seg2;
  assign seg0 = {a0, b0, c0, d0, e0, f0, g0};
  assign seg1 = {a1, b1, c1, d1, e1, f1, g1};
  assign seg2 = {a2, b2, c2, d2, e2, f2, g2};

  // Glyph table as drawn on a display, on=1, {a..g}.
  logic [6:0] glyph_tbl [16];
  initial begin
    glyph_tbl[0]  = 7'b1111110; glyph_tbl[1]  = 7'b0110000;
    glyph_tbl[2]  = 7'b1101101; glyph_tbl[3]  = 7'b1111001;
    glyph_tbl[4]  = 7'b0110011; glyph_tbl[5]  = 7'b1011011;
    glyph_tbl[6]  = 7'b1011111; glyph_tbl[7]  = 7'b1110000;
    glyph_tbl[8]  = 7'b1111111; glyph_tbl[9]  = 7'b1111011;
    glyph_tbl[10] = 7'b1110111; glyph_tbl[11] = 7'b0011111;
    glyph_tbl[12] = 7'b1001110; glyph_tbl[13] = 7'b0111101;
    glyph_tbl[14] = 7'b1001111; glyph_tbl[15] = 7'b1000111;
  end

  // Returns {segments_as_driven, invalid}.
  function automatic logic [7:0] model(bit al, bit hex, logic r, logic lt,
                                       logic bl, logic [3:0] code);
    logic [6:0] s;
    logic       inv;
    inv = 1'b0;
    if (r)                          s = 7'd0;
    else if (lt)                    s = 7'h7F;
    else if (bl)                    s = 7'd0;
    else if (code >= 10 && !hex) begin s = 7'd0; inv = 1'b1; end
    else                            s = glyph_tbl[code];
    if (al) s = ~s;
    return {s, inv};
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got seg=%b inv=%b, expected seg=%b inv=%b",
               name, act[7:1], act[0], exp[7:1], exp[0]);
    end
  endtask

  logic [7:0] exp0, exp1, exp2;
  logic       model_valid = 1'b0;

  always @(posedge clk) begin
    exp0 <= model(1'b0, 1'b1, rst, lamp_test, blank, i);
    exp1 <= model(1'b0, 1'b0, rst, lamp_test, blank, i);
    exp2 <= model(1'b1, 1'b1, rst, lamp_test, blank, i);
    model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc_dut0", {seg0, inv0}, exp0);
      check("cyc_dut1", {seg1, inv1}, exp1);
      check("cyc_dut2", {seg2, inv2}, exp2);
    end
  end

  // Apply inputs, let one edge sample them, then settle past the compare.
  task automatic step(logic r, logic [3:0] code, logic bl, logic lt);
    rst = r; i = code; blank = bl; lamp_test = lt;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] rst=%b i=%0d blank=%b lt=%b -> dut0=%b/%b dut1=%b/%b dut2=%b/%b",
             r, code, bl, lt, seg0, inv0, seg1, inv1, seg2, inv2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    step(1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b1, 4'd0, 1'b0, 1'b0);
    check("reset_dut0", {seg0, inv0}, {7'b0000000, 1'b0});
    check("reset_dut2", {seg2, inv2}, {7'b1111111, 1'b0});

    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'(k), 1'b0, 1'b0);
      if (k == 0) begin
        check("dig0", {seg0, inv0}, {7'b1111110, 1'b0});
        check("dig0_al", {seg2, inv2}, {7'b0000001, 1'b0});
      end
      if (k == 1) check("dig1_al", {seg2, inv2}, {7'b1001111, 1'b0});
      if (k == 8) check("dig8", {seg0, inv0}, {7'b1111111, 1'b0});
      if (k == 9) check("dig9", {seg0, inv0}, {7'b1111011, 1'b0});
    end

    for (int k = 10; k < 16; k++) begin
      step(1'b0, 4'(k), 1'b0, 1'b0);
      check("nohex_blank", {seg1, inv1}, {7'b0000000, 1'b1});
      if (k == 10) check("hexA", {seg0, inv0}, {7'b1110111, 1'b0});
      if (k == 15) check("hexF", {seg0, inv0}, {7'b1000111, 1'b0});
    end

    step(1'b0, 4'd1, 1'b1, 1'b1);
    check("prio_lt", {seg0, inv0}, {7'b1111111, 1'b0});
    step(1'b0, 4'd1, 1'b1, 1'b0);
    check("prio_blank", {seg0, inv0}, {7'b0000000, 1'b0});
    step(1'b0, 4'd1, 1'b0, 1'b0);
    check("prio_decode", {seg0, inv0}, {7'b0110000, 1'b0});

    step(1'b0, 4'd12, 1'b0, 1'b1);
    check("lt_clears_invalid", {seg1, inv1}, {7'b1111111, 1'b0});

    step(1'b1, 4'd8, 1'b0, 1'b0);
    check("midrst", {seg0, inv0}, {7'b0000000, 1'b0});
    step(1'b0, 4'd8, 1'b0, 1'b0);
    check("resume", {seg0, inv0}, {7'b1111111, 1'b0});

    for (int k = 0; k < 64; k++) begin
      step(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
